// File: rtl/mm_pkg.sv
// Shared FSM state type, default dimensions and an index-width helper
// for the matrix multiply-accumulate engine.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int M_DEF  = 4;
    localparam int K_DEF  = 4;
    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;

    // Keeps index ports at least one bit wide when a dimension is 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: full-width product, sign-extended into a
// wrapping accumulator that can be cleared or loaded with a base value.
module mac_unit #(
    parameter int DW = 8,
    parameter int CW = 18
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 load,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [CW-1:0] base,
    output logic signed [CW-1:0] acc
);

    function automatic logic signed [CW-1:0] sext(input logic signed [2*DW-1:0] p);
        return CW'(p);
    endfunction

    logic signed [2*DW-1:0] prod;

    assign prod = a * b;

    // load replaces the running sum with base on the first term of an element
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= (load ? base : acc) + sext(prod);
        end
    end

endmodule

// File: rtl/matmul_mac_engine.sv
// Register-file matrix engine computing C = A*B (+C) one element at a time,
// K multiply-accumulate cycles followed by one write-back cycle per element.
module matmul_mac_engine
    import mm_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int K  = K_DEF,
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = 2*DW + $clog2(K)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 a_we,
    input  logic [idx_w(M)-1:0]  a_row,
    input  logic [idx_w(K)-1:0]  a_col,
    input  logic [DW-1:0]        a_wdata,
    input  logic                 b_we,
    input  logic [idx_w(K)-1:0]  b_row,
    input  logic [idx_w(N)-1:0]  b_col,
    input  logic [DW-1:0]        b_wdata,
    input  logic                 c_re,
    input  logic [idx_w(M)-1:0]  c_row,
    input  logic [idx_w(N)-1:0]  c_col,
    output logic [CW-1:0]        c_rdata,
    output logic                 c_rvalid,
    input  logic                 start,
    input  logic                 accumulate,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam int IW = idx_w(M);
    localparam int KW = idx_w(K);
    localparam int JW = idx_w(N);

    logic signed [DW-1:0] a_mem [M][K];
    logic signed [DW-1:0] b_mem [K][N];
    logic signed [CW-1:0] c_mem [M][N];

    state_t               state_q, state_d;
    logic [IW-1:0]        i_q;
    logic [JW-1:0]        j_q;
    logic [KW-1:0]        k_q;
    logic                 acc_mode_q;
    logic signed [CW-1:0] acc;
    logic signed [CW-1:0] mac_base;
    logic                 frozen, go, k_last, el_last, mac_en, wr_en;

    assign frozen   = (state_q == MAC) || (state_q == WRITE);
    assign go       = (state_q == IDLE) && start && !stop;
    assign k_last   = (k_q == KW'(K-1));
    assign el_last  = (i_q == IW'(M-1)) && (j_q == JW'(N-1));
    assign mac_en   = (state_q == MAC) && !stop;
    assign wr_en    = (state_q == WRITE) && !stop;
    assign mac_base = acc_mode_q ? c_mem[i_q][j_q] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) state_d = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (stop)        state_d = IDLE;
                else if (k_last) state_d = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (stop)         state_d = IDLE;
                else if (el_last) state_d = DONE;
                else              state_d = MAC;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // i/j walk C row-major; k walks the dot product of the current element
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_mode_q <= 1'b0;
        end else if (go) begin
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_mode_q <= accumulate;
        end else if (mac_en) begin
            k_q <= k_last ? '0 : k_q + KW'(1);
        end else if (wr_en && !el_last) begin
            if (j_q == JW'(N-1)) begin
                j_q <= '0;
                i_q <= i_q + IW'(1);
            end else begin
                j_q <= j_q + JW'(1);
            end
        end
    end

    mac_unit #(
        .DW (DW),
        .CW (CW)
    ) u_mac (
        .clk    (clk),
        .resetn (resetn),
        .clr    (go),
        .en     (mac_en),
        .load   (k_q == '0),
        .a      (a_mem[i_q][k_q]),
        .b      (b_mem[k_q][j_q]),
        .base   (mac_base),
        .acc    (acc)
    );

    // operand storage is frozen while a computation is in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < K; c++)
                    a_mem[r][c] <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < N; c++)
                    b_mem[r][c] <= '0;
        end else begin
            if (a_we && !frozen) a_mem[a_row][a_col] <= $signed(a_wdata);
            if (b_we && !frozen) b_mem[b_row][b_col] <= $signed(b_wdata);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    c_mem[r][c] <= '0;
        end else if (wr_en) begin
            c_mem[i_q][j_q] <= acc;
        end
    end

    // nonblocking read returns the pre-write value on a same-cycle collision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            aborted  <= 1'b0;
        end else begin
            c_rvalid <= c_re;
            if (c_re) c_rdata <= c_mem[c_row][c_col];
            aborted  <= frozen && stop;
        end
    end

endmodule
